// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, FSM states and the
// program image. HALT detection is enabled by defining FETCH_HALT_DETECT_EN.
package fetch_unit_pkg;

  localparam int ROM_WORDS = 16;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_SHR   = 4'h8;
  localparam logic [3:0] OP_CMP   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_STORE = 4'hC;
  localparam logic [3:0] OP_MOV   = 4'hD;
  localparam logic [3:0] OP_IN    = 4'hE;
  localparam logic [3:0] HALT_OP  = 4'hF;

  typedef enum logic [1:0] {
    FETCH,
    ISSUE,
    HALT
  } fetch_state_e;

  // Opcode in the top nibble, two 3-bit argument fields below it.
  localparam logic [9:0] ROM_TABLE [ROM_WORDS] = '{
    {OP_ADD,   6'o45}, {OP_LOAD,  6'o13}, {OP_SUB,   6'o22}, {OP_AND,   6'o21},
    {OP_XOR,   6'o14}, {HALT_OP,  6'o00}, {OP_JMP,   6'o47}, {OP_OR,    6'o26},
    {OP_SUB,   6'o63}, {OP_SHR,   6'o71}, {OP_SHL,   6'o44}, {OP_CMP,   6'o72},
    {OP_STORE, 6'o35}, {OP_ADD,   6'o36}, {OP_JZ,    6'o10}, {OP_MOV,   6'o53}
  };

  // Addresses beyond the program image read as zero (NOP).
  function automatic logic [31:0] rom_word(input int unsigned addr);
    if (addr < 32'(ROM_WORDS)) return 32'(ROM_TABLE[addr[3:0]]);
    return '0;
  endfunction

endpackage

// File: rtl/instr_rom.sv
// Combinational program ROM, contents taken from the shared package table.
module instr_rom
  import fetch_unit_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 10
) (
  input  logic [PC_W-1:0]    addr,
  output logic [INSTR_W-1:0] data
);

  assign data = INSTR_W'(rom_word(32'(addr)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH/ISSUE/HALT FSM, pc and instruction registers.
// HALT opcode handling is compiled in only when FETCH_HALT_DETECT_EN is defined.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int OP_SIZE  = 4,
  parameter int ARG_SIZE = 3,
  parameter int ARG_NUM  = 2,
  parameter int PC_W     = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                done,
  input  logic                                branch,
  input  logic [PC_W-1:0]                     branchaddress,
  output logic [OP_SIZE+ARG_NUM*ARG_SIZE-1:0] instruction,
  output logic                                instr_valid,
  output logic [PC_W-1:0]                     pc,
  output logic                                halted
);

  localparam int INSTR_W = OP_SIZE + ARG_NUM * ARG_SIZE;

  fetch_state_e         state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [INSTR_W-1:0]   rom_data;

  instr_rom #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_rom (
    .addr (pc_q),
    .data (rom_data)
  );

`ifdef FETCH_HALT_DETECT_EN
  logic is_halt_op;
  assign is_halt_op = (instr_q[INSTR_W-1 -: OP_SIZE] == {OP_SIZE{1'b1}});
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      FETCH: begin
        instr_d = rom_data;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (done) begin
`ifdef FETCH_HALT_DETECT_EN
          if (is_halt_op) begin
            state_d = HALT;
          end else begin
            pc_d    = branch ? branchaddress : pc_q + PC_W'(1);
            state_d = FETCH;
          end
`else
          pc_d    = branch ? branchaddress : pc_q + PC_W'(1);
          state_d = FETCH;
`endif
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = (state_q == ISSUE);
  assign pc          = pc_q;

`ifdef FETCH_HALT_DETECT_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random done/branch
// traffic compared against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam logic [9:0] EXP_ROM [16] = '{
    10'h0A5, 10'h04B, 10'h0D2, 10'h111, 10'h18C, 10'h3C0, 10'h2A7, 10'h156,
    10'h0F3, 10'h239, 10'h1E4, 10'h27A, 10'h31D, 10'h09E, 10'h2C8, 10'h36B
  };

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic       branch;
  logic [3:0] branchaddress;
  logic [9:0] instruction;
  logic       instr_valid;
  logic [3:0] pc;
  logic       halted;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the word the core currently holds and where it came from.
  logic [3:0] m_pc;
  logic [9:0] m_instr;
  bit         m_valid;
  bit         m_halted;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .done          (done),
    .branch        (branch),
    .branchaddress (branchaddress),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},          32'(pc),          32'(m_pc));
    check({tag, ".instruction"}, 32'(instruction), 32'(m_instr));
    check({tag, ".instr_valid"}, 32'(instr_valid), 32'(m_valid));
    check({tag, ".halted"},      32'(halted),      32'(m_halted));
  endtask

  task automatic model_reset();
    m_pc = '0; m_instr = '0; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  // One clock edge of the fetch stream as seen from outside.
  task automatic model_edge(input bit d, input bit b, input logic [3:0] ba);
    if (m_halted) return;
    if (!m_valid) begin
      m_instr = EXP_ROM[m_pc];
      m_valid = 1'b1;
    end else if (d) begin
      m_valid = 1'b0;
      if (HALT_EN && m_instr[9:6] == 4'hF) m_halted = 1'b1;
      else if (b) m_pc = ba;
      else m_pc = 4'((int'(m_pc) + 1) % 16);
    end
  endtask

  // Inputs are applied 1 time unit after an edge; outputs checked 1 after the next.
  task automatic cycle(input string tag, input bit d, input bit b, input logic [3:0] ba);
    done = d; branch = b; branchaddress = ba;
    @(posedge clk);
    model_edge(d, b, ba);
    #1;
    check_all(tag);
  endtask

  task automatic goto_addr(input logic [3:0] addr);
    cycle("goto_done", 1'b1, 1'b1, addr);
    cycle("goto_fetch", 1'b0, 1'b0, 4'h0);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; done = 1'b0; branch = 1'b0; branchaddress = '0;
    model_reset();
    #12;
    check_all("reset");

    @(posedge clk);
    #1;
    rst = 1'b1;
    check_all("release");
    cycle("first_fetch", 1'b0, 1'b0, 4'h0);
    check("first_word", 32'(instruction), 32'h0A5);

    // Branch from pc=2 to 12.
    cycle("adv0", 1'b1, 1'b0, 4'h0);
    cycle("fetch1", 1'b0, 1'b0, 4'h0);
    cycle("adv1", 1'b1, 1'b0, 4'h0);
    cycle("fetch2", 1'b0, 1'b0, 4'h0);
    goto_addr(4'hC);
    check("branch_pc", 32'(pc), 32'd12);
    check("branch_word", 32'(instruction), 32'h31D);

    // Sequential advance from pc=3: one bubble, then rom[4].
    goto_addr(4'h3);
    cycle("seq_done", 1'b1, 1'b0, 4'h0);
    check("seq_bubble", 32'(instr_valid), 32'd0);
    cycle("seq_fetch", 1'b0, 1'b0, 4'h0);
    check("seq_word", 32'(instruction), 32'h18C);

    // Wrap from 15 to 0, then branch without done is ignored.
    goto_addr(4'hF);
    cycle("wrap_done", 1'b1, 1'b0, 4'h0);
    cycle("wrap_fetch", 1'b0, 1'b0, 4'h0);
    check("wrap_pc", 32'(pc), 32'd0);
    for (int i = 0; i < 5; i++) cycle("branch_no_done", 1'b0, 1'b1, 4'h9);

    // done held high: one advance per ISSUE visit.
    for (int i = 0; i < 6; i++) cycle("done_held", 1'b1, 1'b0, 4'h0);
    cycle("done_held_end", 1'b0, 1'b0, 4'h0);

    // Reset in ISSUE at pc=7 drops the word and restarts at 0.
    goto_addr(4'h7);
    reset_pulse();
    cycle("refetch", 1'b0, 1'b0, 4'h0);
    check("refetch_pc", 32'(pc), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (m_halted || $urandom_range(0, 59) == 0) reset_pulse();
      cycle("random", $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
    end

    // HALT opcode at pc=5, then repeated done pulses with branch.
    reset_pulse();
    cycle("halt_fetch0", 1'b0, 1'b0, 4'h0);
    goto_addr(4'h5);
    cycle("halt_done", 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      cycle("halt_pulse", 1'b1, 1'b1, 4'($urandom_range(0, 15)));
      cycle("halt_idle", 1'b0, 1'b0, 4'h0);
    end
    reset_pulse();
    cycle("post_halt_fetch", 1'b0, 1'b0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
